lo_nco: RTL and testbench
=========================

Name: lo_nco

Overview:
- Parametrised numerically-controlled local oscillator for the mixer datapath.
- Produces quadrature cosine/sine samples from a phase accumulator with a run-time frequency tuning word (FTW) and a phase offset.
- Uses a quarter-wave-symmetric amplitude table.
- With default parameters and default FTW it emits the legacy 16-step, ±100 cosine sequence, and adds sine, enable, phase clear, frequency load and output-valid.

Parameters:
- OUT_W, 9: signed output sample width.
- AMP, 100: peak amplitude. Must be ≤ 2^(OUT_W-1)-1.
- PHASE_W, 16: phase accumulator / FTW / offset width.
- LUT_AW, 4: log2 of table points per full cycle (N = 2^LUT_AW). Must satisfy 3 ≤ LUT_AW ≤ PHASE_W.
- FTW_DEFAULT, 2^(PHASE_W-LUT_AW): FTW value after reset (one table step per sample).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance oscillator and launch one sample this cycle.
- phase_clr  in  1  synchronous phase restart.
- ftw_load  in  1  load ftw_in into the FTW register.
- ftw_in  in  PHASE_W  new tuning word (unsigned).
- phase_off  in  PHASE_W  phase offset added before table lookup (unsigned, mod 2^PHASE_W).
- cos_out  out  OUT_W  signed cosine sample.
- sin_out  out  OUT_W  signed sine sample.
- out_valid  out  1  cos_out/sin_out hold a new sample this cycle.

Behaviour:
- Reset (rst_n low, async):
  - acc=0, ftw=FTW_DEFAULT, pipeline regs=0.
  - cos_out=0, sin_out=0, out_valid=0.
  - Takes effect immediately, mid-operation included.
  - Release is synchronous to clk.
- Table: Q[k] = round_half_away(AMP*cos(2πk/N)) for k=0..N/4, stored once.
- Full-cycle lookup C[i], i in 0..N-1, derived by symmetry:
  - quadrant 0: Q[i]
  - quadrant 1: -Q[N/2-i]
  - quadrant 2: -Q[i-N/2]
  - quadrant 3: Q[N-i]
  - Defaults give 100,92,71,38,0,-38,-71,-92,-100,-92,-71,-38,0,38,71,92.
- Stage 1, cycle n, en=1:
  - p = (phase_clr ? 0 : acc) + phase_off, mod 2^PHASE_W.
  - i = p[PHASE_W-1 -: LUT_AW] (truncation, no dither).
  - Register i.
  - acc <= (phase_clr ? 0 : acc) + ftw, mod 2^PHASE_W.
- Stage 2, cycle n+1: registers cos_out=C[i] and sin_out=C[(i-N/4) mod N]. Outputs are visible after the n+1 edge.
- Latency: 2 clocks from the en=1 sample edge to out_valid=1.
  - out_valid is en delayed by 2 registers.
  - Throughput: 1 sample/clock.
- en=0:
  - acc holds.
  - No sample launched.
  - cos_out/sin_out hold their last value.
  - out_valid=0 two cycles later.
  - Resuming continues the phase sequence with no skipped or repeated index.
- phase_clr:
  - Acts only when en=1.
  - The sample launched that cycle uses phase 0 (+phase_off).
  - The next sample uses ftw.
  - With en=0, phase_clr sets acc<=0 and launches nothing.
- ftw_load:
  - ftw <= ftw_in at the edge.
  - The accumulate in the same cycle uses the old ftw; the new value applies from the next cycle.
  - Independent of en.
- Simultaneous phase_clr and ftw_load with en=1:
  - Sample phase is 0.
  - acc <= old ftw.
  - New ftw is used thereafter.
- ftw=0: constant output C[index of phase_off].
- ftw ≥ 2^(PHASE_W-1): aliasing allowed, wraps mod 2^PHASE_W, no error flag.
- Outputs never exceed ±AMP. The -AMP code is always representable.

Test Plan:
- Reset, then en=1 continuously, defaults:
  - out_valid=1 from the 2nd edge.
  - cos_out = 100,92,71,38,0,-38,-71,-92,-100,-92,-71,-38,0,38,71,92, repeating (period 16).
  - sin_out = 0,38,71,92,100,92,71,38,0,-38,... in the same cycles.
- ftw_load with ftw_in=0x2000 after reset, then en=1:
  - cos_out = 100,71,0,-71,-100,-71,0,71 (period 8).
  - Load issued mid-stream changes step size starting one sample later.
- phase_off=0x4000, default FTW, en=1 from reset: cos_out = 0,-38,-71,-92,-100,...; sin_out = 100,92,71,...
- en=1 for 5 samples (cos 100..0), then en=0 for 3 cycles, then en=1:
  - Outputs hold at 0.
  - out_valid low for exactly 3 cycles.
  - Next valid sample is -38.
- phase_clr pulsed with en=1 when the index is 9: the sample it launches is 100, the next is 92; verify again with ftw_load in the same cycle.
- rst_n asserted asynchronously between edges mid-stream:
  - cos_out=sin_out=0 and out_valid=0 immediately.
  - After release with en=1, the sequence restarts at 100 with FTW_DEFAULT.

Source files
------------

// File: rtl/lo_nco.sv
// lo_nco: quadrature NCO, phase accumulator with run-time FTW/offset feeding a quarter-wave cosine table.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         advance accumulator and launch one sample
//   phase_clr  restart phase (sample uses phase 0 + offset); clears acc even when en=0
//   ftw_load   load ftw_in into the tuning-word register
//   ftw_in     new tuning word
//   phase_off  phase offset added before lookup
//   cos_out    signed cosine sample
//   sin_out    signed sine sample
//   out_valid  cos_out/sin_out carry a new sample this cycle
module lo_nco #(
    parameter int OUT_W = 9,
    parameter int AMP = 100,
    parameter int PHASE_W = 16,
    parameter int LUT_AW = 4,
    parameter logic [PHASE_W-1:0] FTW_DEFAULT = PHASE_W'(1) << (PHASE_W - LUT_AW)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      phase_clr,
    input  logic                      ftw_load,
    input  logic [PHASE_W-1:0]        ftw_in,
    input  logic [PHASE_W-1:0]        phase_off,
    output logic signed [OUT_W-1:0]   cos_out,
    output logic signed [OUT_W-1:0]   sin_out,
    output logic                      out_valid
);
    localparam int N = 1 << LUT_AW;
    localparam int QN = N / 4;

    // Evaluated only with constant arguments, so the real math folds away at elaboration.
    function automatic logic signed [OUT_W-1:0] q_val(input int k);
        real v;
        v = AMP * $cos(2.0 * 3.141592653589793 * k / N);
        return OUT_W'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
    endfunction

    logic signed [OUT_W-1:0] q_tab [QN+1];
    for (genvar k = 0; k <= QN; k++) begin : g_tab
        assign q_tab[k] = q_val(k);
    end

    logic [PHASE_W-1:0]       acc_q, acc_d, ftw_q, ftw_d, base;
    logic [LUT_AW-1:0]        idx_q, idx_d;
    logic                     vld1_q, vld1_d, vld2_q, vld2_d;
    logic signed [OUT_W-1:0]  cos_q, cos_d, sin_q, sin_d;
    logic [LUT_AW-1:0]        lut_i [2];
    logic [LUT_AW-2:0]        mag [2];
    logic signed [OUT_W-1:0]  lut_v [2];

    always_comb begin
        base = phase_clr ? '0 : acc_q;
        acc_d = base + (en ? ftw_q : '0);
        ftw_d = ftw_load ? ftw_in : ftw_q;
        idx_d = en ? LUT_AW'((base + phase_off) >> (PHASE_W - LUT_AW)) : idx_q;
        vld1_d = en;
        vld2_d = vld1_q;
        lut_i[0] = idx_q;
        lut_i[1] = idx_q - LUT_AW'(QN);
        // Odd quadrants mirror the table index; quadrants 1 and 2 negate.
        for (int c = 0; c < 2; c++) begin
            mag[c] = lut_i[c][LUT_AW-2] ? (LUT_AW-1)'(QN) - {1'b0, lut_i[c][LUT_AW-3:0]}
                                        : {1'b0, lut_i[c][LUT_AW-3:0]};
            lut_v[c] = (lut_i[c][LUT_AW-1] ^ lut_i[c][LUT_AW-2]) ? -q_tab[mag[c]] : q_tab[mag[c]];
        end
        cos_d = vld1_q ? lut_v[0] : cos_q;
        sin_d = vld1_q ? lut_v[1] : sin_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ftw_q  <= FTW_DEFAULT;
            idx_q  <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            cos_q  <= '0;
            sin_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            ftw_q  <= ftw_d;
            idx_q  <= idx_d;
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            cos_q  <= cos_d;
            sin_q  <= sin_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;
    assign out_valid = vld2_q;
endmodule

// File: tb/tb_lo_nco.sv
// tb_lo_nco: directed and random checks of lo_nco against an arithmetic phase/trig reference.
module tb_lo_nco;
    localparam real PI = 3.141592653589793;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, phase_clr = 1'b0, ftw_load = 1'b0;
    logic [15:0] ftw_in = '0, phase_off = '0;
    logic signed [8:0] cos_out, sin_out;
    logic out_valid;
    int total = 0, bad = 0;
    int m_acc, m_ftw, s1_idx, m_cos, m_sin;
    bit s1_v, m_valid;
    int leg [16] = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
    int p8 [8] = '{100, 71, 0, -71, -100, -71, 0, 71};

    always #5 clk = ~clk;

    lo_nco dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr), .ftw_load(ftw_load),
        .ftw_in(ftw_in), .phase_off(phase_off), .cos_out(cos_out), .sin_out(sin_out),
        .out_valid(out_valid)
    );

    function automatic int rnd(input real v);
        return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_acc = 0; m_ftw = 4096; s1_idx = 0; s1_v = 0; m_cos = 0; m_sin = 0; m_valid = 0;
    endtask

    task automatic step(input bit e, input bit c, input bit l, input int f, input int o);
        int b;
        en = e; phase_clr = c; ftw_load = l; ftw_in = f[15:0]; phase_off = o[15:0];
        @(posedge clk);
        if (s1_v) begin
            m_cos = rnd(100.0 * $cos(2.0 * PI * s1_idx / 16.0));
            m_sin = rnd(100.0 * $sin(2.0 * PI * s1_idx / 16.0));
        end
        m_valid = s1_v;
        b = c ? 0 : m_acc;
        s1_v = e;
        if (e) s1_idx = ((b + (o % 65536)) % 65536) / 4096;
        m_acc = (b + (e ? m_ftw : 0)) % 65536;
        if (l) m_ftw = f % 65536;
        #1;
        chk("cos", cos_out, m_cos);
        chk("sin", sin_out, m_sin);
        chk("valid", out_valid, m_valid);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw_load = 1'b0; phase_off = '0;
        #1;
        chk("rst_cos", cos_out, 0);
        chk("rst_sin", sin_out, 0);
        chk("rst_valid", out_valid, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #2;
        chk("init_cos", cos_out, 0);
        chk("init_sin", sin_out, 0);
        chk("init_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 34; j++) begin
            step(1, 0, 0, 0, 0);
            if (j >= 2) begin
                chk("leg_cos", cos_out, leg[(j - 2) % 16]);
                chk("leg_sin", sin_out, leg[(j + 10) % 16]);
                chk("leg_valid", out_valid, 1);
            end
        end
        do_reset();
        for (int j = 1; j <= 4; j++) begin
            step(1, 0, 0, 0, 0);
            if (j >= 2) chk("restart_cos", cos_out, leg[j - 2]);
        end
        do_reset();
        step(0, 0, 1, 16'h2000, 0);
        for (int j = 1; j <= 10; j++) begin
            step(1, 0, 0, 0, 0);
            if (j >= 2) chk("ftw8_cos", cos_out, p8[(j - 2) % 8]);
        end
        step(1, 0, 1, 16'h1000, 0);
        for (int j = 0; j < 6; j++) step(1, 0, 0, 0, 0);
        do_reset();
        for (int j = 1; j <= 10; j++) begin
            step(1, 0, 0, 0, 16'h4000);
            if (j >= 2) begin
                chk("off_cos", cos_out, leg[(j + 2) % 16]);
                chk("off_sin", sin_out, leg[(j - 2) % 16]);
            end
        end
        do_reset();
        for (int j = 1; j <= 12; j++) begin
            step(j <= 5 || j >= 9, 0, 0, 0, 0);
            if (j >= 7 && j <= 9) begin
                chk("pause_cos", cos_out, 0);
                chk("pause_valid", out_valid, 0);
            end
            if (j == 10) begin
                chk("resume_cos", cos_out, -38);
                chk("resume_valid", out_valid, 1);
            end
        end
        do_reset();
        for (int j = 1; j <= 23; j++) begin
            step(1, j == 10 || j == 19, j == 19, 16'h2000, 0);
            if (j == 11 || j == 20) chk("clr_cos0", cos_out, 100);
            if (j == 12 || j == 21) chk("clr_cos1", cos_out, 92);
            if (j == 22) chk("clr_load_cos2", cos_out, 38);
        end
        do_reset();
        step(0, 0, 1, 0, 0);
        for (int j = 0; j < 5; j++) step(1, 0, 0, 0, 16'h6000);
        chk("ftw0_cos", cos_out, -71);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 16'hF000, 0);
        for (int j = 0; j < 4; j++) step(1, 0, 0, 0, 0);
        for (int j = 0; j < 250; j++)
            step($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
                 int'($urandom_range(65535)), int'($urandom_range(65535)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
